// File: rtl/serial_max_fsm.sv
// serial_max_fsm: bit-serial unsigned comparator that streams max(A,B), MSB first
// Ports: clk, reset (sync, active-low), ai/bi serial operand bits,
//        [minsel when FSM_MIN_SEL_EN is defined: 1 selects min(A,B)],
//        out (Mealy output bit), debugstate (registered state: 00 EQ, 01 AGT, 10 BGT).
// Optional feature macro: FSM_MIN_SEL_EN
module serial_max_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic       ai,
  input  logic       bi,
`ifdef FSM_MIN_SEL_EN
  input  logic       minsel,
`endif
  output logic       out,
  output logic [1:0] debugstate
);
  typedef enum logic [1:0] {EQ = 2'b00, AGT = 2'b01, BGT = 2'b10, ILL = 2'b11} state_t;
  state_t state, next_state;
  logic max_bit;
  always_ff @(posedge clk) begin
    if (!reset) state <= EQ;
    else state <= next_state;
  end
  // The first differing bit decides the winner; AGT/BGT then hold until reset.
  always_comb begin
    next_state = state;
    next_state = (state == ILL) ? EQ :
                 (state == EQ && ai != bi) ? (ai ? AGT : BGT) : state;
  end
  // In EQ the larger operand is the one carrying a 1, so OR gives its bit.
  always_comb begin
    max_bit = (state == AGT) ? ai : (state == BGT) ? bi : (ai | bi);
  end
`ifdef FSM_MIN_SEL_EN
  logic min_bit;
  always_comb begin
    min_bit = (state == AGT) ? bi : (state == BGT) ? ai : (ai & bi);
    out = !reset ? 1'b0 : minsel ? min_bit : max_bit;
  end
`else
  always_comb begin
    out = !reset ? 1'b0 : max_bit;
  end
`endif
  assign debugstate = state;
endmodule

// File: tb/tb_serial_max_fsm.sv
// tb_serial_max_fsm: directed self-checking bench for serial_max_fsm
module tb_serial_max_fsm;
  logic clk = 1'b0;
  logic reset, ai, bi;
  logic out;
  logic [1:0] debugstate;
  int checks = 0;
  int errors = 0;
`ifdef FSM_MIN_SEL_EN
  logic minsel = 1'b0;
`endif
  always #5 clk = ~clk;
  serial_max_fsm dut (
    .clk(clk),
    .reset(reset),
    .ai(ai),
    .bi(bi),
`ifdef FSM_MIN_SEL_EN
    .minsel(minsel),
`endif
    .out(out),
    .debugstate(debugstate)
  );
  task automatic chk_out(input logic exp, input string tag);
    checks++;
    assert (out === exp) else begin
      errors++;
      $error("FAIL %s out=%0b expected=%0b", tag, out, exp);
    end
  endtask
  task automatic chk_state(input logic [1:0] exp, input string tag);
    checks++;
    assert (debugstate === exp) else begin
      errors++;
      $error("FAIL %s debugstate=%b expected=%b", tag, debugstate, exp);
    end
  endtask
  // Drive one bit pair, check Mealy out and the pre-edge state, then clock it in.
  task automatic step(input logic a, input logic b, input logic r,
                      input logic eo, input logic [1:0] es, input string tag);
    reset = r; ai = a; bi = b;
    #2;
    chk_out(eo, tag);
    chk_state(es, tag);
    @(posedge clk);
    #1;
  endtask
  // Stream a 9-bit frame MSB first; state is EQ before bit index sw, st from then on.
  task automatic frame(input logic [8:0] a, input logic [8:0] b, input logic [8:0] eo,
                       input int sw, input logic [1:0] st, input string tag);
    for (int i = 0; i < 9; i++)
      step(a[8-i], b[8-i], 1'b1, eo[8-i], (i >= sw) ? st : 2'b00, $sformatf("%s_b%0d", tag, i));
    #2;
    chk_state((sw <= 9) ? st : 2'b00, {tag, "_end"});
  endtask
  initial begin
    reset = 1'b0; ai = 1'b1; bi = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    #2;
    chk_out(1'b0, "reset_out");
    chk_state(2'b00, "reset_state");
    frame(9'b000000111, 9'b000011111, 9'b000011111, 5, 2'b10, "bgt");
    step(1'b1, 1'b1, 1'b0, 1'b0, 2'b10, "rst1");
    frame(9'b000011111, 9'b000000111, 9'b000011111, 5, 2'b01, "agt");
    step(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, "rst2");
    frame(9'b010110101, 9'b010110111, 9'b010110111, 8, 2'b10, "late");
    step(1'b0, 1'b1, 1'b0, 1'b0, 2'b10, "rst3");
    frame(9'b101010101, 9'b101010101, 9'b101010101, 10, 2'b00, "equal");
    step(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, "rst4");
    step(1'b1, 1'b0, 1'b1, 1'b1, 2'b00, "to_agt");
    step(1'b0, 1'b1, 1'b1, 1'b0, 2'b01, "agt_sticky");
    step(1'b0, 1'b1, 1'b0, 1'b0, 2'b01, "mid_reset");
    step(1'b0, 1'b1, 1'b1, 1'b1, 2'b00, "after_reset");
    step(1'b1, 1'b0, 1'b1, 1'b0, 2'b10, "bgt_sticky");
    step(1'b1, 1'b1, 1'b1, 1'b1, 2'b10, "bgt_ones");
`ifdef FSM_MIN_SEL_EN
    step(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, "rst_min");
    minsel = 1'b1;
    frame(9'b000000111, 9'b000011111, 9'b000000111, 5, 2'b10, "min");
    step(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, "rst_min2");
    frame(9'b000011111, 9'b000000111, 9'b000000111, 5, 2'b01, "min_agt");
    minsel = 1'b0;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
